// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator for the decode stage.
// Classifies the instruction format, builds the sign/zero-extended immediate
// and carries a sideband tag, with a valid/ready handshake and flush.
// STAGES=2 registers classify and assemble separately; STAGES=1 does both
// combinationally ahead of a single output register.
// Optional feature: define IMM_GEN_ZICSR_EN to decode SYSTEM CSR forms as
// fmt 6 (CSR address or uimm). Without it SYSTEM is plain I-type.
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_CSR = 3'd6;
    localparam logic [2:0] FMT_ILL = 3'd7;

    // Format classification from opcode (and funct3 for SYSTEM when CSR decode is on).
    function automatic logic [2:0] classify(input logic [31:0] i);
        logic [2:0] f;
        f = FMT_ILL;
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: f = FMT_I;
            7'b0011011: f = (XLEN == 64) ? FMT_I : FMT_ILL;
            7'b0100011: f = FMT_S;
            7'b1100011: f = FMT_B;
            7'b0110111, 7'b0010111: f = FMT_U;
            7'b1101111: f = FMT_J;
            7'b0110011: f = FMT_R;
            7'b1110011: begin
`ifdef IMM_GEN_ZICSR_EN
                // funct3[2] selects the uimm forms; funct3 0 is ECALL/EBREAK-style I, 4 is reserved.
                if (i[14])
                    f = (i[13:12] == 2'b00) ? FMT_ILL : FMT_CSR;
                else
                    f = (i[13:12] == 2'b00) ? FMT_I : FMT_CSR;
`else
                f = FMT_I;
`endif
            end
            default: f = FMT_ILL;
        endcase
        return f;
    endfunction

    // Immediate assembly from instruction payload bits [31:7] and the format.
    // Every sign-extended form is first built as a signed 32-bit value and then
    // widened, so U-type is sign-extended as well when XLEN is 64.
    function automatic logic [XLEN-1:0] assemble(input logic [31:7] i, input logic [2:0] f);
        logic signed [31:0] v;
        logic [XLEN-1:0]    r;
        v = '0;
        case (f)
            FMT_I:   v = {{20{i[31]}}, i[31:20]};
            FMT_S:   v = {{20{i[31]}}, i[31:25], i[11:7]};
            FMT_B:   v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            FMT_U:   v = {i[31:12], 12'b0};
            FMT_J:   v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: v = '0;
        endcase
        r = XLEN'(v);
        // CSR forms are zero-extended: 5-bit uimm when funct3[2] is set, else the 12-bit CSR address.
        if (f == FMT_CSR)
            r = i[14] ? XLEN'(i[19:15]) : XLEN'(i[31:20]);
        return r;
    endfunction

    generate
        if (STAGES == 1) begin : g_one
            logic             r_v1;
            logic [XLEN-1:0]  r_imm1;
            logic [2:0]       r_fmt1;
            logic [TAG_W-1:0] r_tag1;
            logic [2:0]       w_fmt;

            assign w_fmt    = classify(inst);
            assign in_ready = !r_v1 || out_ready;

            // Output stage: classify + assemble in front of the only register.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_v1   <= 1'b0;
                    r_imm1 <= '0;
                    r_fmt1 <= '0;
                    r_tag1 <= '0;
                end else if (flush) begin
                    r_v1 <= 1'b0;
                end else if (in_ready) begin
                    r_v1 <= in_valid;
                    if (in_valid) begin
                        r_imm1 <= assemble(inst[31:7], w_fmt);
                        r_fmt1 <= w_fmt;
                        r_tag1 <= in_tag;
                    end
                end
            end

            assign out_valid = r_v1;
            assign imm       = r_imm1;
            assign fmt       = r_fmt1;
            assign out_tag   = r_tag1;
            assign illegal   = (r_fmt1 == FMT_ILL);
        end else begin : g_two
            logic             r_v0;
            logic [31:7]      r_bits0;
            logic [2:0]       r_fmt0;
            logic [TAG_W-1:0] r_tag0;
            logic             r_v1;
            logic [XLEN-1:0]  r_imm1;
            logic [2:0]       r_fmt1;
            logic [TAG_W-1:0] r_tag1;
            logic             w_s1_adv;

            // Output stage can take a new entry when empty or when its entry leaves.
            assign w_s1_adv = !r_v1 || out_ready;
            assign in_ready = !r_v0 || w_s1_adv;

            // Stage 0: classify and latch the payload bits needed for assembly.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_v0    <= 1'b0;
                    r_bits0 <= '0;
                    r_fmt0  <= '0;
                    r_tag0  <= '0;
                end else if (flush) begin
                    r_v0 <= 1'b0;
                end else if (in_ready) begin
                    r_v0 <= in_valid;
                    if (in_valid) begin
                        r_bits0 <= inst[31:7];
                        r_fmt0  <= classify(inst);
                        r_tag0  <= in_tag;
                    end
                end
            end

            // Stage 1: assemble the immediate; holds while the consumer stalls.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_v1   <= 1'b0;
                    r_imm1 <= '0;
                    r_fmt1 <= '0;
                    r_tag1 <= '0;
                end else if (flush) begin
                    r_v1 <= 1'b0;
                end else if (w_s1_adv) begin
                    r_v1 <= r_v0;
                    if (r_v0) begin
                        r_imm1 <= assemble(r_bits0, r_fmt0);
                        r_fmt1 <= r_fmt0;
                        r_tag1 <= r_tag0;
                    end
                end
            end

            assign out_valid = r_v1;
            assign imm       = r_imm1;
            assign fmt       = r_fmt1;
            assign out_tag   = r_tag1;
            assign illegal   = (r_fmt1 == FMT_ILL);
        end
    endgenerate

endmodule
